// File: rtl/led_blink_multi.sv
// led_blink_multi: multi-channel LED driver.
// Each channel runs its own IDLE/ON/OFF sequencer. The run-time mode selects
// off, steady on, continuous blink, or a triggered burst of N pulses.
// Optional build macro LED_BLINK_MULTI_DIM_EN adds the dim_duty port and a
// shared 4-bit PWM that gates every lit LED.
module led_blink_multi #(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 16,
    parameter int BLINK_ON_CLKS  = 1024,
    parameter int BLINK_OFF_CLKS = 1024,
    parameter int BURST_W        = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2*NUM_CH-1:0]   mode,
    input  logic [NUM_CH-1:0]     trigger,
    input  logic [BURST_W-1:0]    burst_len,
`ifdef LED_BLINK_MULTI_DIM_EN
    input  logic [3:0]            dim_duty,
`endif
    output logic [NUM_CH-1:0]     led,
    output logic [NUM_CH-1:0]     busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_STEADY = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_BURST  = 2'b11
    } mode_t;

    // Counters count down to zero, so each phase loads its length minus one.
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(BLINK_ON_CLKS - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(BLINK_OFF_CLKS - 1);

    // Brightness gate shared by all channels (always open without dimming).
    logic dim_ok;

`ifdef LED_BLINK_MULTI_DIM_EN
    logic [3:0] pwm_cnt;

    // Free-running PWM phase; a lit LED shows only while the phase is <= duty.
    always_ff @(posedge clk) begin
        if (reset) pwm_cnt <= 4'd0;
        else       pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign dim_ok = (pwm_cnt <= dim_duty);
`else
    assign dim_ok = 1'b1;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t             state_q, state_d;
        logic [CNT_W-1:0]   cnt_q, cnt_d;
        logic [BURST_W-1:0] rem_q, rem_d;
        logic [BURST_W-1:0] rem_eff;
        logic               on_d;
        logic               led_q, busy_q;
        logic               retrig;
        mode_t              ch_mode;

        assign ch_mode = mode_t'(mode[2*g +: 2]);
        assign retrig  = (ch_mode == MODE_BURST) && trigger[g];
        // A trigger in this cycle refills the burst before any end-of-OFF decision.
        assign rem_eff = retrig ? burst_len : rem_q;

        // Next-state, counter and LED level for this channel.
        always_comb begin
            // NOTE: every output of this block gets a default first so no latch is inferred.
            state_d = state_q;
            cnt_d   = cnt_q;
            rem_d   = rem_q;
            on_d    = 1'b0;
            case (ch_mode)
                MODE_OFF: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rem_d   = '0;
                end
                MODE_STEADY: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rem_d   = '0;
                    on_d    = 1'b1;
                end
                default: begin
                    rem_d = rem_eff;
                    case (state_q)
                        ST_IDLE: begin
                            if (ch_mode == MODE_BLINK) begin
                                state_d = ST_ON;
                                cnt_d   = ON_LOAD;
                            end else if (trigger[g] && (burst_len != '0)) begin
                                // The first pulse starts now and counts toward the burst.
                                state_d = ST_ON;
                                cnt_d   = ON_LOAD;
                                rem_d   = burst_len - BURST_W'(1);
                            end
                        end
                        ST_ON: begin
                            if (cnt_q == '0) begin
                                state_d = ST_OFF;
                                cnt_d   = OFF_LOAD;
                            end else begin
                                cnt_d = cnt_q - CNT_W'(1);
                            end
                        end
                        ST_OFF: begin
                            if (cnt_q != '0) begin
                                cnt_d = cnt_q - CNT_W'(1);
                            end else if (ch_mode == MODE_BLINK) begin
                                state_d = ST_ON;
                                cnt_d   = ON_LOAD;
                            end else if (rem_eff != '0) begin
                                state_d = ST_ON;
                                cnt_d   = ON_LOAD;
                                rem_d   = rem_eff - BURST_W'(1);
                            end else begin
                                state_d = ST_IDLE;
                                cnt_d   = '0;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    endcase
                    on_d = (state_d == ST_ON);
                end
            endcase
        end

        // Channel state and registered outputs; reset clears everything.
        always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            if (reset) begin
                // NOTE: counters are reset too, so no channel can wake with a stale phase or burst count.
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                rem_q   <= '0;
                led_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rem_q   <= rem_d;
                led_q   <= on_d & dim_ok;
                busy_q  <= (state_d != ST_IDLE);
            end
        end

        assign led[g]  = led_q;
        assign busy[g] = busy_q;
    end

endmodule
